// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, default fetch
// parameters and the instruction word field layout.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;

   localparam int unsigned FIELD_W    = 8;
   localparam int unsigned OPCODE_LSB = 24;
   localparam int unsigned DEST_LSB   = 16;
   localparam int unsigned SRC1_LSB   = 8;
   localparam int unsigned SRC2_LSB   = 0;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] dest;
      logic [7:0] src1;
      logic [7:0] src2;
   } instr_t;

   function automatic instr_t unpack_instr(input logic [31:0] word);
      instr_t r;
      r.opcode = word[OPCODE_LSB +: FIELD_W];
      r.dest   = word[DEST_LSB   +: FIELD_W];
      r.src1   = word[SRC1_LSB   +: FIELD_W];
      r.src2   = word[SRC2_LSB   +: FIELD_W];
      return r;
   endfunction

endpackage

// File: rtl/instr_fetch_pc_calc.sv
// Combinational address arithmetic for the fetch unit: sequential increments
// and the PC-relative branch target (word offset, wraps modulo 2^32).
module pc_calc
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
   input  logic [31:0] fetch_pc_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] branch_base_i,
   input  logic [7:0]  offset_i,
   output logic [31:0] fetch_pc_inc_o,
   output logic [31:0] pc_inc_o,
   output logic [31:0] target_o
);

   logic [31:0] byte_offset;

   always_comb begin
      byte_offset    = {{22{offset_i[7]}}, offset_i, 2'b00};
      fetch_pc_inc_o = fetch_pc_i + PC_STEP;
      pc_inc_o       = pc_i + PC_STEP;
      target_o       = branch_base_i + byte_offset;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues reads to instruction memory, holds one
// instruction for the CPU and handles branch redirects, including mid-read.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic        IMEM_READ,
   output logic [31:0] IMEM_ADDR,
   input  logic [31:0] IMEM_INSTR,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC,
   output logic        INS_VALID,
   input  logic        CPU_STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [7:0]  BRANCH_OFFSET
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  base_q, base_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  target_q, target_d;
   instr_t       instr_q, instr_d;
   logic         valid_q, valid_d;

   logic [31:0]  fetch_pc_inc;
   logic [31:0]  pc_inc;
   logic [31:0]  branch_tgt;

   pc_calc #(.PC_STEP(PC_STEP)) u_pc_calc (
      .fetch_pc_i     (fetch_pc_q),
      .pc_i           (pc_q),
      .branch_base_i  (base_q),
      .offset_i       (BRANCH_OFFSET),
      .fetch_pc_inc_o (fetch_pc_inc),
      .pc_inc_o       (pc_inc),
      .target_o       (branch_tgt)
   );

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         base_q     <= RESET_PC;
         pc_q       <= RESET_PC;
         target_q   <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         base_q     <= base_d;
         pc_q       <= pc_d;
         target_q   <= target_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      base_d     = base_q;
      pc_d       = pc_q;
      target_d   = target_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      case (state_q)
         FETCH: begin
            if (BRANCH_TAKEN) begin
               // A read still in flight must complete before the redirect.
               if (IMEM_BUSYWAIT) begin
                  target_d = branch_tgt;
                  state_d  = FLUSH;
               end else begin
                  fetch_pc_d = branch_tgt;
               end
            end else if (!IMEM_BUSYWAIT) begin
               instr_d    = unpack_instr(IMEM_INSTR);
               pc_d       = fetch_pc_q;
               valid_d    = 1'b1;
               fetch_pc_d = fetch_pc_inc;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (BRANCH_TAKEN) begin
               valid_d    = 1'b0;
               fetch_pc_d = branch_tgt;
               state_d    = FETCH;
            end else if (valid_q && !CPU_STALL) begin
               base_d  = pc_inc;
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         FLUSH: begin
            if (BRANCH_TAKEN) begin
               target_d = branch_tgt;
            end
            if (!IMEM_BUSYWAIT) begin
               fetch_pc_d = BRANCH_TAKEN ? branch_tgt : target_q;
               state_d    = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      IMEM_READ   = RESET_N && (state_q != HOLD);
      IMEM_ADDR   = fetch_pc_q;
      INSTRUCTION = instr_q;
      PC          = pc_q;
      INS_VALID   = valid_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: default instance plus one reset at the top
// of the address space to exercise wrap and reset-during-flush.
module tb_instr_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Instance A: default parameters
   logic        a_rst_n, a_read, a_busy, a_valid, a_stall, a_br;
   logic [31:0] a_addr, a_rdata, a_instr, a_pc;
   logic [7:0]  a_off;

   // Instance B: RESET_PC at the last word
   logic        b_rst_n, b_read, b_busy, b_valid, b_stall, b_br;
   logic [31:0] b_addr, b_rdata, b_instr, b_pc;
   logic [7:0]  b_off;

   // Memory returns a word that encodes its own address
   assign a_rdata = 32'hFF03_0201 + a_addr;
   assign b_rdata = 32'hFF03_0201 + b_addr;

   instr_fetch u_dut_a (
      .CLK           (clk),
      .RESET_N       (a_rst_n),
      .IMEM_READ     (a_read),
      .IMEM_ADDR     (a_addr),
      .IMEM_INSTR    (a_rdata),
      .IMEM_BUSYWAIT (a_busy),
      .INSTRUCTION   (a_instr),
      .PC            (a_pc),
      .INS_VALID     (a_valid),
      .CPU_STALL     (a_stall),
      .BRANCH_TAKEN  (a_br),
      .BRANCH_OFFSET (a_off)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_dut_b (
      .CLK           (clk),
      .RESET_N       (b_rst_n),
      .IMEM_READ     (b_read),
      .IMEM_ADDR     (b_addr),
      .IMEM_INSTR    (b_rdata),
      .IMEM_BUSYWAIT (b_busy),
      .INSTRUCTION   (b_instr),
      .PC            (b_pc),
      .INS_VALID     (b_valid),
      .CPU_STALL     (b_stall),
      .BRANCH_TAKEN  (b_br),
      .BRANCH_OFFSET (b_off)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rst_n = 1'b0; a_busy = 1'b0; a_stall = 1'b0; a_br = 1'b0; a_off = 8'h00;
      b_rst_n = 1'b0; b_busy = 1'b0; b_stall = 1'b0; b_br = 1'b0; b_off = 8'h00;
      step();
      step();

      // Reset state
      chk("a_rst_read",  {31'd0, a_read},  32'd0);
      chk("a_rst_valid", {31'd0, a_valid}, 32'd0);
      chk("a_rst_pc",    a_pc,    32'h0);
      chk("a_rst_instr", a_instr, 32'h0);
      chk("a_rst_addr",  a_addr,  32'h0);

      // First fetch one edge after release
      a_rst_n = 1'b1;
      #1;
      chk("a_rel_read", {31'd0, a_read}, 32'd1);
      step();
      chk("a_f0_valid", {31'd0, a_valid}, 32'd1);
      chk("a_f0_pc",    a_pc,    32'h0);
      chk("a_f0_instr", a_instr, 32'hFF03_0201);
      chk("a_f0_addr",  a_addr,  32'h4);
      chk("a_f0_read",  {31'd0, a_read}, 32'd0);
      step();  // transfer
      chk("a_xfer0_valid", {31'd0, a_valid}, 32'd0);

      // Stall while holding PC=4
      a_stall = 1'b1;
      step();
      chk("a_f4_pc", a_pc, 32'h4);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("a_stall_valid", {31'd0, a_valid}, 32'd1);
         chk("a_stall_pc",    a_pc,    32'h4);
         chk("a_stall_instr", a_instr, 32'hFF03_0205);
         chk("a_stall_read",  {31'd0, a_read}, 32'd0);
         chk("a_stall_addr",  a_addr,  32'h8);
      end
      a_stall = 1'b0;
      step();
      chk("a_unstall_valid", {31'd0, a_valid}, 32'd0);
      chk("a_unstall_read",  {31'd0, a_read},  32'd1);

      // Busywait three cycles at address 8
      a_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("a_busy_read",  {31'd0, a_read}, 32'd1);
         chk("a_busy_addr",  a_addr, 32'h8);
         chk("a_busy_valid", {31'd0, a_valid}, 32'd0);
      end
      a_busy = 1'b0;
      step();
      chk("a_f8_valid", {31'd0, a_valid}, 32'd1);
      chk("a_f8_pc",    a_pc,    32'h8);
      chk("a_f8_instr", a_instr, 32'hFF03_0209);
      chk("a_f8_addr",  a_addr,  32'hC);

      step();  // transfer PC=8
      step();  // fetch PC=12
      chk("a_f12_pc", a_pc, 32'hC);
      step();  // transfer PC=12, base=16
      step();  // fetch PC=16
      chk("a_f16_pc", a_pc, 32'h10);

      // Branch back by two words from base 16 while holding PC=16
      a_br = 1'b1; a_off = 8'hFE;
      step();
      a_br = 1'b0; a_off = 8'h00;
      chk("a_brh_valid", {31'd0, a_valid}, 32'd0);
      chk("a_brh_addr",  a_addr, 32'h8);
      chk("a_brh_read",  {31'd0, a_read}, 32'd1);
      step();
      chk("a_brh_pc",    a_pc,    32'h8);
      chk("a_brh_instr", a_instr, 32'hFF03_0209);

      // Mid-operation reset, then branch during busywait after consuming PC=0
      a_rst_n = 1'b0;
      step();
      chk("a_rst2_addr",  a_addr, 32'h0);
      chk("a_rst2_valid", {31'd0, a_valid}, 32'd0);
      a_rst_n = 1'b1;
      step();  // fetch PC=0
      chk("a_r0_pc", a_pc, 32'h0);
      step();  // transfer, base=4
      a_busy = 1'b1; a_br = 1'b1; a_off = 8'h03;
      step();
      a_br = 1'b0; a_off = 8'h00;
      chk("a_fl_read",  {31'd0, a_read}, 32'd1);
      chk("a_fl_addr",  a_addr, 32'h4);
      chk("a_fl_valid", {31'd0, a_valid}, 32'd0);
      step();
      chk("a_fl_addr2", a_addr, 32'h4);
      a_busy = 1'b0;
      step();
      chk("a_fl_done_valid", {31'd0, a_valid}, 32'd0);
      chk("a_fl_done_addr",  a_addr,  32'h10);
      chk("a_fl_done_instr", a_instr, 32'hFF03_0201);
      step();
      chk("a_f16b_pc",    a_pc,    32'h10);
      chk("a_f16b_instr", a_instr, 32'hFF03_0211);

      // Branch in FETCH with data ready: data dropped, stay in FETCH
      step();  // transfer PC=16, base=20
      a_br = 1'b1; a_off = 8'h01;
      step();
      a_br = 1'b0; a_off = 8'h00;
      chk("a_brf_valid", {31'd0, a_valid}, 32'd0);
      chk("a_brf_addr",  a_addr, 32'h18);
      chk("a_brf_read",  {31'd0, a_read}, 32'd1);
      step();
      chk("a_brf_pc",    a_pc,    32'h18);
      chk("a_brf_instr", a_instr, 32'hFF03_0219);

      // Instance B: wrap at the top of memory
      chk("b_rst_read", {31'd0, b_read}, 32'd0);
      chk("b_rst_addr", b_addr, 32'hFFFF_FFFC);
      b_rst_n = 1'b1;
      step();
      chk("b_f0_pc",    b_pc,    32'hFFFF_FFFC);
      chk("b_f0_instr", b_instr, 32'hFF03_01FD);
      chk("b_wrap_addr", b_addr, 32'h0);
      step();  // transfer, base wraps to 0
      b_busy = 1'b1; b_br = 1'b1; b_off = 8'h05;
      step();  // FLUSH, target 20
      chk("b_fl_addr", b_addr, 32'h0);
      b_off = 8'h02;
      step();  // overwrite target with 8
      b_br = 1'b0; b_off = 8'h00;
      b_busy = 1'b0;
      step();
      chk("b_ovw_addr",  b_addr, 32'h8);
      chk("b_ovw_valid", {31'd0, b_valid}, 32'd0);
      b_busy = 1'b1; b_br = 1'b1; b_off = 8'h01;
      step();  // FLUSH again
      b_br = 1'b0; b_off = 8'h00;
      chk("b_fl2_read", {31'd0, b_read}, 32'd1);

      // Reset during FLUSH with data returning on the same edge
      b_busy = 1'b0; b_rst_n = 1'b0;
      #1;
      chk("b_rstfl_read_now", {31'd0, b_read}, 32'd0);
      step();
      chk("b_rstfl_read",  {31'd0, b_read}, 32'd0);
      chk("b_rstfl_addr",  b_addr,  32'hFFFF_FFFC);
      chk("b_rstfl_valid", {31'd0, b_valid}, 32'd0);
      chk("b_rstfl_instr", b_instr, 32'h0);
      b_rst_n = 1'b1;
      step();
      chk("b_post_valid", {31'd0, b_valid}, 32'd1);
      chk("b_post_pc",    b_pc,   32'hFFFF_FFFC);
      chk("b_post_addr",  b_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
